linear_network_multicast_arbiter: RTL and testbench
===================================================

# linear_network_multicast_arbiter

Round-robin, burst-aware arbiter and sequencer in front of the sequential linear multicast distribution network. It shares the network's single injection port between NUM_REQ requesters, each offering data beats tagged with a one-hot-per-node destination mask. It drives the network's `i_valid`, `i_data_bus`, `i_cmd` and `i_en` from registered outputs. It tracks beats still travelling down the chain so that software and upstream control can detect when the network has drained.

## Interface
- DATA_WIDTH, 32, beat width; equals network DATA_WIDTH.
- NUM_NODE, 4, network node count; equals the destination mask width. Must be ≥2.
- NUM_REQ, 4, number of requesters. Must be ≥2. ID_W = $clog2(NUM_REQ).

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- i_req_valid  input  NUM_REQ  per-requester beat valid.
- i_req_data  input  NUM_REQ*DATA_WIDTH  requester r on [r*DATA_WIDTH+:DATA_WIDTH].
- i_req_dest  input  NUM_REQ*NUM_NODE  requester r mask on [r*NUM_NODE+:NUM_NODE]; bit k set delivers to node k.
- i_req_last  input  NUM_REQ  beat is the last of its burst.
- o_req_ready  output  NUM_REQ  beat accepted at the edge where valid&ready.
- i_stall  input  1  downstream freeze request.
- o_net_valid  output  1  to network i_valid (registered).
- o_net_data  output  DATA_WIDTH  to network i_data_bus (registered).
- o_net_cmd  output  NUM_NODE  to network i_cmd (registered).
- o_net_en  output  1  to network i_en; combinational, = ~i_stall.
- o_grant_id  output  ID_W  requester that owns the current o_net beat (registered).
- o_drop  output  1  one-cycle pulse: a zero-mask beat was accepted and discarded.
- o_idle  output  1  no lock held, no beat in the output register or in the network.

## Operation
- State machine has two states, IDLE and LOCKED. It also holds a round-robin pointer `ptr` (ID_W bits) and a lock owner `own`.
- IDLE:
  - Grant goes to the first requester with valid set, searching `ptr`, `ptr`+1, … modulo NUM_REQ.
  - Only the granted requester sees ready=1, and only when `i_stall`=0.
  - Accept with last=1: stay in IDLE and set `ptr` = granted+1 mod NUM_REQ.
  - Accept with last=0: go to LOCKED with `own` = granted.
- LOCKED:
  - Only `own` can see ready, gated by ~`i_stall`. Other valids are ignored.
  - Accept with last=1: go to IDLE and set `ptr` = `own`+1 mod NUM_REQ.
  - An idle gap in the owner's valid keeps the lock.
- Ready is combinational from state, `ptr`, `i_req_valid` and `i_stall`. Valid must not depend on ready.
- Output register update, on an edge with `i_stall`=0:
  - o_net_valid = accepted AND (dest ≠ 0).
  - o_net_data, o_net_cmd and o_grant_id load the accepted beat's data, mask and ID. With no accept they hold their previous value and o_net_valid=0.
- Zero-mask beat: accepted normally (burst and lock rules still apply), never issued. o_drop=1 for the cycle after the accept.
- Stall: while `i_stall`=1, the following all hold:
  - all ready=0;
  - output registers, state, `ptr`, `own` and the tracker do not change;
  - o_drop=0;
  - o_net_en=0, so the network freezes as well.
- Drain tracker: `occ[NUM_NODE-1:0]`. On each edge with `i_stall`=0, `occ` <= {`occ`[NUM_NODE-2:0], o_net_valid}.
- o_idle = (state==IDLE) & ~o_net_valid & (`occ`==0).

## Timing
- Reset: at an edge with rst=0, all of the following clear:
  - state=IDLE, `ptr`=0, `own`=0;
  - o_net_valid=0, o_net_data=0, o_net_cmd=0, o_grant_id=0;
  - `occ`=0, o_drop=0.
- While rst=0, o_req_ready=0 and o_idle=1. o_net_en still follows ~`i_stall`.
- Reset mid-burst drops the lock and any in-flight tracking. There is no partial-beat recovery.
- Accept at edge t puts o_net_valid/data/cmd on the network port during cycle t..t+1. Node k's output valid appears k+1 enabled cycles later, matching the network's per-switch register.
- Throughput is one beat per cycle. A requester releasing its grant in IDLE can be re-granted only after all other valid requesters have had a turn.
- o_idle rises NUM_NODE enabled edges after the last issued beat leaves the output register.
- Stall asserted in the cycle o_net_valid=1: that beat is held and is sampled exactly once, by the network at the first edge with `i_stall`=0.

## Test plan
- Single-beat round robin: reset; req 0..3 all valid with last=1 and dest=4'b0001,0010,0100,1000. Required: grants in order 0,1,2,3 on consecutive cycles; o_grant_id=0,1,2,3; o_net_cmd matches each dest; `ptr` wraps to 0 and req0 is granted next.
- Burst lock: req1 sends 3 beats (last on the 3rd) while req2 is valid throughout. Required: req2 ready=0 until req1's last beat is accepted; req2 granted on the next cycle; a 1-cycle gap inside req1's burst does not release the lock.
- Multicast/drain: one beat with dest=4'b1011, NUM_NODE=4. Required: o_net_cmd=1011; o_idle=0 for 5 cycles after the accept (1 output-register cycle + 4 tracker cycles), then 1.
- Zero mask: req3 beat with dest=0, last=1. Required: ready=1 and accept; o_net_valid stays 0; o_drop=1 for exactly one cycle; `ptr` becomes 0.
- Stall: assert `i_stall` for 3 cycles while o_net_valid=1 with data=32'hA5A5_0001. Required: o_net_en=0, all ready=0, and o_net_data held; after release the beat is presented for exactly one enabled edge.
- Reset mid-burst: rst=0 while LOCKED on req2. Required: the next cycle shows state IDLE, o_net_valid=0, `occ`=0, and the first grant goes to the lowest valid index starting from 0.

Source files
------------

// File: rtl/linear_network_multicast_arbiter.sv
// linear_network_multicast_arbiter: round-robin, burst-locking injector for the linear multicast network
module linear_network_multicast_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE = 4,
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
  input  logic [NUM_REQ*NUM_NODE-1:0]    i_req_dest,
  input  logic [NUM_REQ-1:0]             i_req_last,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic                           i_stall,
  output logic                           o_net_valid,
  output logic [DATA_WIDTH-1:0]          o_net_data,
  output logic [NUM_NODE-1:0]            o_net_cmd,
  output logic                           o_net_en,
  output logic [ID_W-1:0]                o_grant_id,
  output logic                           o_drop,
  output logic                           o_idle
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, nstate;
  logic [ID_W-1:0] ptr, nptr, own, nown, gnt, sel;
  logic [NUM_NODE-1:0] occ, dest;
  logic [DATA_WIDTH-1:0] data;
  logic any, has, acc, last, drop_q;
  int d, best;
  always_comb begin
    gnt = '0;
    any = 1'b0;
    best = NUM_REQ;
    d = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j - int'(ptr) + NUM_REQ) % NUM_REQ;
      if (i_req_valid[j] && d < best) begin
        best = d;
        gnt = ID_W'(j);
        any = 1'b1;
      end
    end
  end
  assign sel = (state == LOCKED) ? own : gnt;
  assign has = (state == LOCKED) ? i_req_valid[own] : any;
  assign acc = rst & ~i_stall & has;
  assign last = i_req_last[sel];
  assign dest = i_req_dest[sel*NUM_NODE +: NUM_NODE];
  assign data = i_req_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign o_req_ready = acc ? NUM_REQ'(1) << sel : '0;
  assign o_net_en = ~i_stall;
  // a pending drop pulse is held across a stall and shown in the first enabled cycle
  assign o_drop = drop_q & ~i_stall;
  assign o_idle = ~rst | ((state == IDLE) & ~o_net_valid & ~|occ);
  always_comb begin
    nstate = state;
    nptr = ptr;
    nown = own;
    if (acc) begin
      nstate = last ? IDLE : LOCKED;
      nown = last ? own : sel;
      nptr = last ? ((sel == ID_W'(NUM_REQ-1)) ? '0 : sel + 1'b1) : ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      own <= '0;
      o_net_valid <= 1'b0;
      o_net_data <= '0;
      o_net_cmd <= '0;
      o_grant_id <= '0;
      occ <= '0;
      drop_q <= 1'b0;
    end else if (!i_stall) begin
      state <= nstate;
      ptr <= nptr;
      own <= nown;
      o_net_valid <= acc & |dest;
      drop_q <= acc & ~|dest;
      occ <= {occ[NUM_NODE-2:0], o_net_valid};
      if (acc) begin
        o_net_data <= data;
        o_net_cmd <= dest;
        o_grant_id <= sel;
      end
    end
  end
endmodule

// File: tb/tb_linear_network_multicast_arbiter.sv
// tb_linear_network_multicast_arbiter: randomized requesters against a queue-based reference model
module tb_linear_network_multicast_arbiter;
  localparam int DW = 32, NN = 4, NR = 4, IW = 2;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [NN-1:0] dest;
  } ent_t;
  logic clk = 1'b0, rst, stall;
  logic [NR-1:0] req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [NR*NN-1:0] req_dest;
  logic net_valid, net_en, drop, idle;
  logic [DW-1:0] net_data;
  logic [NN-1:0] net_cmd;
  logic [IW-1:0] grant_id;
  int checks = 0, errors = 0;
  ent_t q[$];
  logic [NR-1:0] exp_ready;
  bit mlocked;
  int mptr, mown, drain;
  bit hold[NR], hlast[NR];
  logic [DW-1:0] hdata[NR];
  logic [NN-1:0] hdest[NR];
  int left[NR];
  linear_network_multicast_arbiter #(.DATA_WIDTH(DW), .NUM_NODE(NN), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_dest(req_dest), .i_req_last(req_last), .o_req_ready(req_ready),
    .i_stall(stall), .o_net_valid(net_valid), .o_net_data(net_data),
    .o_net_cmd(net_cmd), .o_net_en(net_en), .o_grant_id(grant_id),
    .o_drop(drop), .o_idle(idle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, expv);
    end
  endtask
  task automatic new_beat(input int r);
    if (left[r] == 0) left[r] = $urandom_range(1, 4);
    hlast[r] = (left[r] == 1);
    hdest[r] = ($urandom_range(7) == 0) ? '0 : NN'($urandom_range(1, 15));
    hdata[r] = $urandom;
    hold[r] = 1'b1;
  endtask
  task automatic drive_and_predict();
    int r;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = hold[i];
      req_last[i] = hlast[i];
      req_data[i*DW +: DW] = hdata[i];
      req_dest[i*NN +: NN] = hdest[i];
    end
    exp_ready = '0;
    if (rst && !stall) begin
      if (mlocked) begin
        if (hold[mown]) exp_ready[mown] = 1'b1;
      end else begin
        for (int k = NR-1; k >= 0; k--) begin
          r = (mptr + k) % NR;
          if (hold[r]) exp_ready = NR'(1) << r;
        end
      end
    end
  endtask
  initial begin
    rst = 1'b0;
    stall = 1'b0;
    mlocked = 0;
    mptr = 0;
    mown = 0;
    for (int i = 0; i < NR; i++) begin
      hold[i] = 0;
      left[i] = 0;
      hlast[i] = 0;
      hdata[i] = '0;
      hdest[i] = '0;
    end
    drive_and_predict();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      left[i] = 1;
      hlast[i] = 1;
      hdest[i] = NN'(1) << i;
      hdata[i] = 32'hA5A5_0000 + i;
      hold[i] = 1;
    end
    drive_and_predict();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (!rst) begin
        q.delete();
        mlocked = 0;
        mptr = 0;
        mown = 0;
      end else if (!stall) begin
        for (int r = 0; r < NR; r++) if (exp_ready[r]) begin
          q.push_back('{id: IW'(r), data: hdata[r], dest: hdest[r]});
          if (hlast[r]) begin
            mlocked = 0;
            mptr = (r + 1) % NR;
          end else begin
            mlocked = 1;
            mown = r;
          end
          hold[r] = 0;
          left[r]--;
        end
      end
      #1;
      rst = !(cyc == 1500 || cyc == 1501);
      stall = (cyc > 8) && (cyc < 2960) && ($urandom_range(7) == 0);
      if (cyc > 4 && cyc < 2950)
        for (int r = 0; r < NR; r++) if (!hold[r] && $urandom_range(3) != 0) new_beat(r);
      drive_and_predict();
    end
    @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  always @(negedge clk) begin
    ent_t ent;
    bit ev, evv;
    chk("net_en", 64'(net_en), 64'(!stall));
    if (!rst) begin
      chk("reset_ready", 64'(req_ready), 64'd0);
      chk("reset_idle", 64'(idle), 64'd1);
      drain = 0;
    end else begin
      ev = q.size() > 0;
      ent = ev ? q[0] : '0;
      evv = ev && (ent.dest != 0);
      chk("ready", 64'(req_ready), 64'(exp_ready));
      chk("net_valid", 64'(net_valid), 64'(evv));
      chk("drop", 64'(drop), 64'(ev && ent.dest == 0 && !stall));
      chk("idle", 64'(idle), 64'(!mlocked && !evv && drain == 0));
      if (evv) begin
        chk("net_data", 64'(net_data), 64'(ent.data));
        chk("net_cmd", 64'(net_cmd), 64'(ent.dest));
        chk("grant_id", 64'(grant_id), 64'(ent.id));
      end
      if (!stall) begin
        drain = evv ? NN : (drain > 0 ? drain - 1 : 0);
        if (ev) void'(q.pop_front());
      end
    end
  end
endmodule
